// File: rtl/huffman_pkg.sv
// Shared types and the fixed prefix-code table for the Huffman encoder.
package huffman_pkg;

  localparam int NUM_SYMS = 8;
  localparam int MAX_LEN  = 7;
  localparam int LEN_W    = 3;
  localparam int IDX_W    = $clog2(NUM_SYMS);

  // Code bits are left-aligned: the first bit to send is bits[MAX_LEN-1].
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] bits;
  } code_t;

  localparam code_t CODE_TABLE [NUM_SYMS] = '{
    '{len: 3'd1, bits: 7'b0000000},
    '{len: 3'd2, bits: 7'b1000000},
    '{len: 3'd3, bits: 7'b1100000},
    '{len: 3'd4, bits: 7'b1110000},
    '{len: 3'd5, bits: 7'b1111000},
    '{len: 3'd6, bits: 7'b1111100},
    '{len: 3'd7, bits: 7'b1111110},
    '{len: 3'd7, bits: 7'b1111111}
  };

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/huffman_code_rom.sv
// Combinational symbol -> prefix code lookup; hit=0 for symbols with no entry.
module huffman_code_rom
  import huffman_pkg::*;
#(
  parameter int SYM_W = 6
) (
  input  logic [SYM_W-1:0]   sym,
  output logic               hit,
  output logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] bits
);

  // Out-of-range symbols return an all-zero entry with hit low.
  always_comb begin
    hit  = 1'b0;
    len  = '0;
    bits = '0;
    if (32'(sym) < 32'(NUM_SYMS)) begin
      hit  = 1'b1;
      len  = CODE_TABLE[sym[IDX_W-1:0]].len;
      bits = CODE_TABLE[sym[IDX_W-1:0]].bits;
    end
  end

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: one code bit per clock, MSB first, gapless between symbols.
module huffman_encoder #(
  parameter int SYM_W   = 6,
  parameter int MAX_LEN = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             e,
  output logic             e_valid,
  output logic             sym_err,
  output logic [CNT_W-1:0] bit_count
);
  import huffman_pkg::*;

  state_e             state_q;
  logic [MAX_LEN-1:0] sh_q;
  logic [LEN_W-1:0]   rem_q;
  logic               e_q;
  logic               ev_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               rom_hit;
  logic [LEN_W-1:0]   rom_len;
  logic [MAX_LEN-1:0] rom_bits;
  logic               xfer;

  huffman_code_rom #(.SYM_W(SYM_W)) u_rom (
    .sym  (sym),
    .hit  (rom_hit),
    .len  (rom_len),
    .bits (rom_bits)
  );

  // Ready whenever the line is free or carrying the final bit of a code.
  always_comb begin
    sym_ready = (state_q == IDLE) || (rem_q == '0);
    xfer      = sym_valid && sym_ready;
  end

  // Encoder FSM: load a code on transfer, shift it out, drop back to IDLE when starved.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      e_q     <= 1'b0;
      ev_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == SHIFT && rem_q != '0) begin
        e_q   <= sh_q[MAX_LEN-1];
        sh_q  <= sh_q << 1;
        rem_q <= rem_q - 3'd1;
      end else if (xfer && rom_hit) begin
        state_q <= SHIFT;
        e_q     <= rom_bits[MAX_LEN-1];
        ev_q    <= 1'b1;
        sh_q    <= rom_bits << 1;
        rem_q   <= rom_len - 3'd1;
      end else begin
        // Starved, or an invalid symbol was taken: line goes quiet.
        state_q <= IDLE;
        e_q     <= 1'b0;
        ev_q    <= 1'b0;
        sh_q    <= '0;
        rem_q   <= '0;
        err_q   <= xfer;
      end
    end
  end

  // Count every bit that has been on the line for a full cycle; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_q <= '0;
    else if (ev_q) cnt_q <= cnt_q + 1'b1;
  end

  assign e         = e_q;
  assign e_valid   = ev_q;
  assign sym_err   = err_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_huffman_encoder.sv
// Bench for huffman_encoder: directed table, reset/wrap sequences, randomized run
// against a queue-based reference model and a prefix decoder on the bit stream.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] sym = '0;
  logic       sym_valid = 1'b0;

  logic        sym_ready, e, e_valid, sym_err;
  logic [15:0] bit_count;
  logic        sym_ready4, e4, e_valid4, sym_err4;
  logic [3:0]  bit_count4;

  always #5 clk = ~clk;

  huffman_encoder dut (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .e(e), .e_valid(e_valid), .sym_err(sym_err),
    .bit_count(bit_count)
  );

  huffman_encoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid),
    .sym_ready(sym_ready4), .e(e4), .e_valid(e_valid4), .sym_err(sym_err4),
    .bit_count(bit_count4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line state: the bit currently on the line plus a queue of bits still owed.
  bit          mq[$];
  bit          m_cv, m_cb, m_err;
  int unsigned m_cnt;

  function automatic bit m_ready();
    return !m_cv || mq.size() == 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cv = 0; m_cb = 0; m_err = 0; m_cnt = 0;
  endtask

  // Code for symbol s: s ones then a zero, except symbol 7 which is seven ones.
  task automatic model_edge(input bit acc, input int s);
    bit code[$];
    if (m_cv) m_cnt++;
    m_err = 0;
    if (mq.size() > 0) begin
      m_cb = mq.pop_front();
    end else if (acc && s < 8) begin
      for (int i = 0; i < ((s == 7) ? 7 : s); i++) code.push_back(1'b1);
      if (s < 7) code.push_back(1'b0);
      m_cb = code.pop_front();
      m_cv = 1;
      mq = code;
    end else begin
      m_err = acc;
      m_cv = 0;
      m_cb = 0;
    end
  endtask

  task automatic check_model();
    chk("e",          e,          m_cb);
    chk("e_valid",    e_valid,    m_cv);
    chk("sym_err",    sym_err,    m_err);
    chk("sym_ready",  sym_ready,  m_ready());
    chk("bit_count",  bit_count,  m_cnt % 65536);
    chk("e_w4",       e4,         m_cb);
    chk("bit_count4", bit_count4, m_cnt % 16);
  endtask

  // Drive one cycle's inputs (from just after a negedge), clock, then check.
  task automatic cycle(input bit v, input logic [5:0] s, output bit acc);
    sym_valid = v;
    sym = s;
    acc = v && m_ready();
    @(posedge clk);
    model_edge(acc, int'(s));
    @(negedge clk);
    check_model();
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before any edge.
  task automatic do_reset();
    sym_valid = 0;
    #2 rst = 0;
    #1;
    chk("rst_e",         e,          0);
    chk("rst_e_valid",   e_valid,    0);
    chk("rst_sym_err",   sym_err,    0);
    chk("rst_bit_count", bit_count,  0);
    chk("rst_cnt4",      bit_count4, 0);
    model_reset();
    @(negedge clk);
    rst = 1;
    #1 chk("rst_ready", sym_ready, 1);
  endtask

  typedef struct {
    bit         v;
    logic [5:0] s;
    bit         e, ev, err, rdy;
    int         cnt;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bit         acc;
    int         n;
    bit         pend;
    logic [5:0] ps;
    int         sentq[$];
    int         ones, got;
    bit         exp_b[4];

    // back-to-back 0,1,7 (stream 0 1 0 1111111)
    tbl[0]  = '{1, 6'd0, 0, 1, 0, 1, 0};
    tbl[1]  = '{1, 6'd1, 1, 1, 0, 0, 1};
    tbl[2]  = '{1, 6'd7, 0, 1, 0, 1, 2};
    tbl[3]  = '{1, 6'd7, 1, 1, 0, 0, 3};
    tbl[4]  = '{1, 6'd7, 1, 1, 0, 0, 4};
    tbl[5]  = '{1, 6'd7, 1, 1, 0, 0, 5};
    tbl[6]  = '{1, 6'd7, 1, 1, 0, 0, 6};
    tbl[7]  = '{1, 6'd7, 1, 1, 0, 0, 7};
    tbl[8]  = '{1, 6'd7, 1, 1, 0, 0, 8};
    tbl[9]  = '{0, 6'd0, 1, 1, 0, 1, 9};
    tbl[10] = '{0, 6'd0, 0, 0, 0, 1, 10};
    // invalid symbol then a single 0
    tbl[11] = '{1, 6'd9, 0, 0, 1, 1, 10};
    tbl[12] = '{1, 6'd0, 0, 1, 0, 1, 10};
    tbl[13] = '{0, 6'd0, 0, 0, 0, 1, 11};
    // single symbol 2 -> 1 1 0
    tbl[14] = '{1, 6'd2, 1, 1, 0, 0, 11};
    tbl[15] = '{0, 6'd0, 1, 1, 0, 0, 12};
    tbl[16] = '{0, 6'd0, 0, 1, 0, 1, 13};
    tbl[17] = '{0, 6'd0, 0, 0, 0, 1, 14};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].s, acc);
      chk($sformatf("tbl%0d_e", i),     e,         tbl[i].e);
      chk($sformatf("tbl%0d_ev", i),    e_valid,   tbl[i].ev);
      chk($sformatf("tbl%0d_err", i),   sym_err,   tbl[i].err);
      chk($sformatf("tbl%0d_rdy", i),   sym_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_cnt", i),   bit_count, tbl[i].cnt);
    end

    // reset in the middle of symbol 6, then symbol 3 -> 1 1 1 0
    cycle(1, 6'd6, acc);
    cycle(0, 6'd0, acc);
    cycle(0, 6'd0, acc);
    chk("mid_ev_before_rst", e_valid, 1);
    do_reset();
    exp_b = '{1, 1, 1, 0};
    cycle(1, 6'd3, acc);
    chk("post_rst_acc", acc, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cycle(0, 6'd0, acc);
      chk($sformatf("post_rst_e%0d", i),  e,       exp_b[i]);
      chk($sformatf("post_rst_ev%0d", i), e_valid, 1);
    end
    cycle(0, 6'd0, acc);
    chk("post_rst_idle", e_valid, 0);

    // counter wrap: three 7s back to back = 21 bits
    do_reset();
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      cycle(1, 6'd7, acc);
      if (acc) n++;
    end
    chk("wrap_accepted", n, 3);
    for (int i = 0; i < 8; i++) cycle(0, 6'd0, acc);
    chk("wrap_cnt4",  bit_count4, 5);
    chk("wrap_cnt16", bit_count,  21);

    // randomized traffic, stream also decoded back into symbols
    do_reset();
    pend = 0; ps = '0; ones = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend = 1;
        ps = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(8, 63))
                                          : 6'($urandom_range(0, 7));
      end
      cycle(pend, pend ? ps : 6'($urandom), acc);
      if (acc) begin
        if (ps < 6'd8) sentq.push_back(int'(ps));
        pend = 0;
      end
      if (e_valid) begin
        got = -1;
        if (e) begin
          ones++;
          if (ones == 7) got = 7;
        end else begin
          got = ones;
        end
        if (got >= 0) begin
          ones = 0;
          if (sentq.size() == 0) chk("dec_sym", got, 32'hFFFF_FFFF);
          else                   chk("dec_sym", got, sentq.pop_front());
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 6'd0, acc);
      if (e_valid) begin
        got = -1;
        if (e) begin
          ones++;
          if (ones == 7) got = 7;
        end else got = ones;
        if (got >= 0) begin
          ones = 0;
          if (sentq.size() == 0) chk("dec_sym", got, 32'hFFFF_FFFF);
          else                   chk("dec_sym", got, sentq.pop_front());
        end
      end
    end
    chk("dec_leftover", sentq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Serial Huffman encoder that sits directly upstream of huffman_decoder and produces the single-bit stream the decoder consumes on its e input.
- Accepts 6-bit symbols over a valid/ready handshake and looks up each symbol's prefix code in a fixed table.
- Shifts each code out MSB-first, one bit per clk, with no idle gap between back-to-back symbols.
- Also keeps a running count of bits emitted.

Parameters:
- SYM_W, 6: symbol width; matches the decoder's s output.
- MAX_LEN, 7: longest code length in bits.
- CNT_W, 16: width of the emitted-bit counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low; rst=0 clears all state immediately.
- sym  in  SYM_W  symbol to encode.
- sym_valid  in  1  sym is valid this cycle.
- sym_ready  out  1  encoder accepts sym this cycle.
- e  out  1  serial code bit to the decoder (registered).
- e_valid  out  1  e carries a code bit this cycle (registered).
- sym_err  out  1  one-cycle pulse: an accepted symbol had no table entry.
- bit_count  out  CNT_W  total bits emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Code table (NUM_SYMS=8), symbol -> code (length):
  - 0 -> 0 (1)
  - 1 -> 10 (2)
  - 2 -> 110 (3)
  - 3 -> 1110 (4)
  - 4 -> 11110 (5)
  - 5 -> 111110 (6)
  - 6 -> 1111110 (7)
  - 7 -> 1111111 (7)
- Symbols >= NUM_SYMS are invalid.
- Reset values (rst=0, asynchronous): e=0, e_valid=0, sym_err=0, bit_count=0, state=IDLE, shift register and remaining count = 0. sym_ready=1 once in IDLE.
- A partially emitted code is abandoned on reset; no resumption.
- States:
  - IDLE: no bit on the line.
  - SHIFT: e_valid=1; rem holds the number of bits still to send after the current one.
- sym_ready = (state==IDLE) or (state==SHIFT and rem==0), i.e. the last bit of the current code is on the line.
- Handshake: a transfer occurs on a rising edge with sym_valid=1 and sym_ready=1.
  - sym must be held stable while sym_valid=1 and sym_ready=0.
- Valid symbol accepted at edge N:
  - At edge N: e <= code MSB, e_valid <= 1, shift register <= remaining bits left-aligned, rem <= len-1, state <= SHIFT.
  - First bit is therefore visible in the cycle after edge N (latency 1). The code occupies exactly len consecutive cycles.
- SHIFT with rem>0: each edge, e <= next bit, rem <= rem-1.
- SHIFT with rem==0 at an edge:
  - Transfer of a valid symbol: load it as above (gapless back-to-back).
  - Transfer of an invalid symbol: go to IDLE.
  - No transfer: go to IDLE, e <= 0, e_valid <= 0.
- Invalid symbol transferred: sym_err=1 for exactly the next cycle, no bits emitted, bit_count unchanged. The next symbol can be accepted on the following edge.
- bit_count increments by 1 on every edge where e_valid=1 (counts bits already on the line); wraps to 0 past 2^CNT_W-1.
- e is 0 whenever e_valid=0.

Decomposition:
- huffman_pkg:
  - NUM_SYMS, MAX_LEN
  - code_t struct: len as 3 bits, bits as MAX_LEN bits left-aligned
  - constant CODE_TABLE[NUM_SYMS]
  - state enum {IDLE, SHIFT}
- Sub-module huffman_code_rom: combinational sym -> {hit, len, bits} lookup over CODE_TABLE. The encoder instantiates it once.

Test Plan:
- Reset: drive rst=0 mid-cycle -> immediately e=0, e_valid=0, sym_err=0, bit_count=0; after rst=1, sym_ready=1.
- Single symbol: sym=2 accepted at edge k -> e=1,1,0 in cycles k+1..k+3 with e_valid=1, then e_valid=0; bit_count=3; sym_ready low only in cycles k+1, k+2.
- Back-to-back: sym_valid held with 0,1,7 -> e stream 0,1,0,1,1,1,1,1,1,1 over 10 consecutive cycles with no gap; bit_count=10; feed e into huffman_decoder and check it outputs s=0,1,7.
- Invalid symbol: sym=6'd9 accepted -> sym_err high exactly 1 cycle, e_valid stays 0, bit_count unchanged; a following sym=0 emits a single 0 bit.
- Reset mid-code: sym=6 accepted, rst=0 after 3 bits emitted -> e=0, e_valid=0, bit_count=0 immediately; after release, sym=3 emits 1,1,1,0.
- Counter wrap (CNT_W=4): three sym=7 back-to-back (21 bits) -> bit_count=5 after the last bit.
